// File: rtl/clint_top.sv
`default_nettype none
// ============================================================================
//  Module      : clint_top
//  Description : Core-local interruptor. Holds the memory-mapped msip,
//                mtimecmp and mtime registers behind a single-outstanding
//                valid/ready request/response port, runs a prescaled
//                free-running mtime counter and drives the machine-timer
//                and machine-software interrupt lines.
//
//  Ports
//    clk         system clock
//    rst         synchronous active-high reset
//    req_valid   request present
//    req_ready   request accepted when high together with req_valid
//    req_wen     1 = write, 0 = read
//    req_addr    byte address (64 bit)
//    req_wdata   write data (64 bit)
//    req_wstrb   byte enables, bit i covers wdata[8i+7:8i]
//    rsp_valid   response present
//    rsp_ready   response consumed when high together with rsp_valid
//    rsp_rdata   read data, 0 for writes and errors
//    rsp_err     unmapped or misaligned access
//    clint_mtip  machine timer interrupt pending (mtime >= mtimecmp)
//    clint_msip  machine software interrupt pending (msip bit 0)
//
//  Revision    : 1.0  initial release
// ============================================================================
module clint_top #(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int unsigned TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wen,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic        clint_mtip,
    output logic        clint_msip
);

    localparam logic [63:0] c_OFS_MSIP     = 64'h0000_0000_0000_0000;
    localparam logic [63:0] c_OFS_MTIMECMP = 64'h0000_0000_0000_4000;
    localparam logic [63:0] c_OFS_MTIME    = 64'h0000_0000_0000_BFF8;
    localparam logic [15:0] c_TICK_LAST    = 16'(TICK_DIV - 1);

    localparam logic [0:0]  c_IDLE = 1'b0;
    localparam logic [0:0]  c_RESP = 1'b1;

    // ------------------------------------------------------------------------
    // State and registers
    // ------------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [0:0]  w_state_next;

    logic [63:0] r_mtime;
    logic [63:0] r_mtimecmp;
    logic        r_msip;
    logic [15:0] r_tick_cnt;
    logic        r_mtip;
    logic        r_msip_out;
    logic [63:0] r_rsp_rdata;
    logic        r_rsp_err;

    // ------------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------------
    logic        w_accept;
    logic [63:0] w_offset;
    logic        w_misaligned;
    logic        w_sel_msip;
    logic        w_sel_mtimecmp;
    logic        w_sel_mtime;
    logic        w_err;
    logic        w_do_write;
    logic        w_wr_msip;
    logic        w_wr_mtimecmp;
    logic        w_wr_mtime;
    logic [63:0] w_mask;
    logic [63:0] w_mtimecmp_merged;
    logic [63:0] w_mtime_merged;
    logic        w_msip_merged;
    logic [63:0] w_rdata;
    logic        w_tick;

    assign w_accept       = req_valid & req_ready;
    assign w_offset       = req_addr - BASE_ADDR;
    assign w_misaligned   = |req_addr[2:0];
    assign w_sel_msip     = ~w_misaligned & (w_offset == c_OFS_MSIP);
    assign w_sel_mtimecmp = ~w_misaligned & (w_offset == c_OFS_MTIMECMP);
    assign w_sel_mtime    = ~w_misaligned & (w_offset == c_OFS_MTIME);
    assign w_err          = ~(w_sel_msip | w_sel_mtimecmp | w_sel_mtime);

    // Error accesses never reach a register because every select is gated.
    assign w_do_write     = w_accept & req_wen;
    assign w_wr_msip      = w_do_write & w_sel_msip;
    assign w_wr_mtimecmp  = w_do_write & w_sel_mtimecmp;
    assign w_wr_mtime     = w_do_write & w_sel_mtime;

    // Byte strobes expanded into a per-bit write mask.
    for (genvar gi = 0; gi < 8; gi++) begin : g_mask
        assign w_mask[8*gi +: 8] = {8{req_wstrb[gi]}};
    end

    assign w_mtimecmp_merged = (r_mtimecmp & ~w_mask) | (req_wdata & w_mask);
    assign w_mtime_merged    = (r_mtime    & ~w_mask) | (req_wdata & w_mask);
    // Only bit 0 of msip exists, so only strobe 0 can change it.
    assign w_msip_merged     = req_wstrb[0] ? req_wdata[0] : r_msip;

    // Read data reflects the registers before this cycle's update.
    always_comb begin
        w_rdata = 64'd0;
        if (w_sel_msip) begin
            w_rdata = {63'd0, r_msip};
        end else if (w_sel_mtimecmp) begin
            w_rdata = r_mtimecmp;
        end else if (w_sel_mtime) begin
            w_rdata = r_mtime;
        end
    end

    assign w_tick = (r_tick_cnt == c_TICK_LAST);

    // ------------------------------------------------------------------------
    // Handshake FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            c_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = c_RESP;
                end
            end
            c_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Response capture; held untouched while the response waits in RESP
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_rdata <= 64'd0;
            r_rsp_err   <= 1'b0;
        end else if (w_accept) begin
            r_rsp_err   <= w_err;
            r_rsp_rdata <= (w_err | req_wen) ? 64'd0 : w_rdata;
        end
    end

    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;

    // ------------------------------------------------------------------------
    // Timer, compare and software-interrupt registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtime    <= 64'd0;
            r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_msip     <= 1'b0;
            r_tick_cnt <= 16'd0;
            r_mtip     <= 1'b0;
            r_msip_out <= 1'b0;
        end else begin
            // Prescaler runs regardless of software writes to mtime.
            if (w_tick) begin
                r_tick_cnt <= 16'd0;
            end else begin
                r_tick_cnt <= r_tick_cnt + 16'd1;
            end

            // A software write wins over the tick increment in the same cycle.
            if (w_wr_mtime) begin
                r_mtime <= w_mtime_merged;
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            if (w_wr_mtimecmp) begin
                r_mtimecmp <= w_mtimecmp_merged;
            end

            if (w_wr_msip) begin
                r_msip <= w_msip_merged;
            end

            // Interrupt lines sample the current register values, so a
            // register change shows up on the line one edge later.
            r_mtip     <= (r_mtime >= r_mtimecmp);
            r_msip_out <= r_msip;
        end
    end

    assign clint_mtip = r_mtip;
    assign clint_msip = r_msip_out;

endmodule
`default_nettype wire
